// File: rtl/ram_pkg.sv
// Shared types for the dual-port byte-enable RAM: read-during-write policy and clear FSM states.
package ram_pkg;

   typedef enum logic {
      RDW_READ_FIRST  = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear sequencer: on clr_req walks an address counter over the whole memory, one word per cycle.
module ram_clr_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_req,
   output logic                  clr_busy,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_busy = 1'b0;
      clr_addr = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            clr_busy = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/ram_dp_be_sync.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, built-in clear sequencer.
// Define RAM_DP_OUTREG_EN to add a second output register stage (read latency 2).
module ram_dp_be_sync
   import ram_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 16,
   parameter rdw_mode_t             RDW_MODE   = RDW_READ_FIRST,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_a,
   input  logic                    we_a,
   input  logic [DATA_WIDTH/8-1:0] be_a,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   din_a,
   output logic [DATA_WIDTH-1:0]   dout_a,
   input  logic                    re_b,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   output logic [DATA_WIDTH-1:0]   dout_b,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic                    collision
);

   localparam int NB          = DATA_WIDTH / 8;
   localparam int DEPTH       = 2 ** ADDR_WIDTH;
   localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_en, wr_hit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged;
   logic [NB-1:0]         wr_be;
   logic [DATA_WIDTH-1:0] rd_a_word, rd_b_word;
   logic                  col_b;

   ram_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_fsm (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_addr (clr_addr)
   );

   // The clear owns the write port while busy; port A writes are dropped then.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr_a;
      wr_data = din_a;
      wr_be   = be_a;
      if (clr_busy) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = CLR_VALUE;
         wr_be   = '1;
      end else if (en_a && we_a) begin
         wr_en = 1'b1;
      end
   end

   assign wr_hit = wr_en && (|wr_be);
   assign wr_old = mem[wr_addr];

   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign wr_merged[8*i +: 8] = wr_be[i] ? wr_data[8*i +: 8] : wr_old[8*i +: 8];
   end

   assign rd_a_word = (WRITE_FIRST && wr_hit && (wr_addr == addr_a)) ? wr_merged : mem[addr_a];
   assign rd_b_word = (WRITE_FIRST && wr_hit && (wr_addr == addr_b)) ? wr_merged : mem[addr_b];
   assign col_b     = wr_hit && (wr_addr == addr_b);

   // NOTE: the storage array has no reset; only the output and control registers do.
   always_ff @(posedge clk) begin
      if (wr_hit) mem[wr_addr] <= wr_merged;
   end

   logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
   logic                  col_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
         col_q  <= 1'b0;
      end else begin
         if (en_a) rd_a_q <= rd_a_word;
         if (re_b) begin
            rd_b_q <= rd_b_word;
            col_q  <= col_b;
         end
      end
   end

`ifdef RAM_DP_OUTREG_EN
   logic                  en_a_q, re_b_q;
   logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
   logic                  col_qq;

   // Enables travel with the data so a held read stays held through both stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_a_q   <= 1'b0;
         re_b_q   <= 1'b0;
         dout_a_q <= '0;
         dout_b_q <= '0;
         col_qq   <= 1'b0;
      end else begin
         en_a_q <= en_a;
         re_b_q <= re_b;
         if (en_a_q) dout_a_q <= rd_a_q;
         if (re_b_q) begin
            dout_b_q <= rd_b_q;
            col_qq   <= col_q;
         end
      end
   end

   assign dout_a    = dout_a_q;
   assign dout_b    = dout_b_q;
   assign collision = col_qq;
`else
   assign dout_a    = rd_a_q;
   assign dout_b    = rd_b_q;
   assign collision = col_q;
`endif

endmodule

// File: tb/tb_ram_dp_be_sync.sv
// Self-checking bench: read-first and write-first instances share stimulus; a queue scoreboard aligns expectations to read latency.
module tb_ram_dp_be_sync;
   import ram_pkg::*;

`ifdef RAM_DP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        en_a, we_a, re_b, clr_req;
   logic [1:0]  be_a;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] din_a;
   logic [15:0] dout_a_rf, dout_b_rf, dout_a_wf, dout_b_wf;
   logic        busy_rf, busy_wf, col_rf, col_wf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_dp_be_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(RDW_READ_FIRST)) u_rf (
      .clk(clk), .reset(reset), .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
      .din_a(din_a), .dout_a(dout_a_rf), .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b_rf),
      .clr_req(clr_req), .clr_busy(busy_rf), .collision(col_rf)
   );

   ram_dp_be_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(RDW_WRITE_FIRST)) u_wf (
      .clk(clk), .reset(reset), .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
      .din_a(din_a), .dout_a(dout_a_wf), .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b_wf),
      .clr_req(clr_req), .clr_busy(busy_wf), .collision(col_wf)
   );

   typedef struct {
      logic        en_a, we_a;
      logic [1:0]  be_a;
      logic [3:0]  addr_a;
      logic [15:0] din_a;
      logic        re_b;
      logic [3:0]  addr_b;
      logic [15:0] a_rf, a_wf, b_rf, b_wf;
      logic        col;
   } vec_t;

   typedef struct {
      string       tag;
      logic [15:0] a_rf, a_wf, b_rf, b_wf;
      logic        col;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = '0; din_a = '0;
      re_b = 1'b0; addr_b = '0; clr_req = 1'b0;
   endtask

   task automatic compare_front();
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_a_rf"}, dout_a_rf, e.a_rf);
      check({e.tag, "_a_wf"}, dout_a_wf, e.a_wf);
      check({e.tag, "_b_rf"}, dout_b_rf, e.b_rf);
      check({e.tag, "_b_wf"}, dout_b_wf, e.b_wf);
      check({e.tag, "_col_rf"}, {15'd0, col_rf}, {15'd0, e.col});
      check({e.tag, "_col_wf"}, {15'd0, col_wf}, {15'd0, e.col});
   endtask

   task automatic step(input string tag, input vec_t v);
      exp_t e;
      en_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; din_a = v.din_a;
      re_b = v.re_b; addr_b = v.addr_b; clr_req = 1'b0;
      e.tag = tag; e.a_rf = v.a_rf; e.a_wf = v.a_wf; e.b_rf = v.b_rf; e.b_wf = v.b_wf; e.col = v.col;
      sb.push_back(e);
      tick();
      if (sb.size() >= LAT) compare_front();
   endtask

   task automatic flush();
      idle_inputs();
      while (sb.size() > 0) begin
         tick();
         compare_front();
      end
   endtask

   task automatic read_all(input string tag, input int cleared_below, input logic [15:0] base);
      vec_t v;
      logic [15:0] w;
      for (int i = 0; i < 16; i++) begin
         w = (i < cleared_below) ? 16'h0000 : base + 16'(i);
         v = '{1'b1, 1'b0, 2'b00, 4'(i), 16'h0, 1'b1, 4'(i), w, w, w, w, 1'b0};
         step($sformatf("%s%0d", tag, i), v);
      end
      flush();
   endtask

   initial begin
      int          busy_n;
      logic [15:0] exp_b;

      tbl[0]  = '{1, 1, 2'b11, 4'd3,  16'hBEEF, 1, 4'd3,  16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 1};
      tbl[1]  = '{1, 1, 2'b10, 4'd3,  16'h1200, 1, 4'd0,  16'hBEEF, 16'h12EF, 16'h0000, 16'h0000, 0};
      tbl[2]  = '{1, 0, 2'b00, 4'd3,  16'h0000, 1, 4'd3,  16'h12EF, 16'h12EF, 16'h12EF, 16'h12EF, 0};
      tbl[3]  = '{1, 1, 2'b11, 4'd5,  16'h1111, 1, 4'd4,  16'h0000, 16'h1111, 16'h0000, 16'h0000, 0};
      tbl[4]  = '{1, 1, 2'b11, 4'd5,  16'h2222, 1, 4'd5,  16'h1111, 16'h2222, 16'h1111, 16'h2222, 1};
      tbl[5]  = '{0, 1, 2'b11, 4'd6,  16'hDEAD, 0, 4'd5,  16'h1111, 16'h2222, 16'h1111, 16'h2222, 1};
      tbl[6]  = '{1, 1, 2'b00, 4'd5,  16'hFFFF, 1, 4'd5,  16'h2222, 16'h2222, 16'h2222, 16'h2222, 0};
      tbl[7]  = '{1, 0, 2'b00, 4'd6,  16'h0000, 1, 4'd3,  16'h0000, 16'h0000, 16'h12EF, 16'h12EF, 0};
      tbl[8]  = '{1, 1, 2'b01, 4'd15, 16'hABCD, 1, 4'd15, 16'h0000, 16'h00CD, 16'h0000, 16'h00CD, 1};
      tbl[9]  = '{1, 0, 2'b00, 4'd15, 16'h0000, 1, 4'd5,  16'h00CD, 16'h00CD, 16'h2222, 16'h2222, 0};
      tbl[10] = '{1, 1, 2'b11, 4'd2,  16'hA5A5, 1, 4'd3,  16'h0000, 16'hA5A5, 16'h12EF, 16'h12EF, 0};
      tbl[11] = '{0, 0, 2'b00, 4'd0,  16'h0000, 1, 4'd2,  16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0};
      tbl[12] = '{0, 0, 2'b00, 4'd0,  16'h0000, 0, 4'd2,  16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0};

      // Reset state.
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout_a_rf", dout_a_rf, 16'h0);
      check("rst_dout_b_wf", dout_b_wf, 16'h0);
      check("rst_col_rf", {15'd0, col_rf}, 16'h0);
      check("rst_busy_rf", {15'd0, busy_rf}, 16'h0);
      check("rst_busy_wf", {15'd0, busy_wf}, 16'h0);
      #3 reset = 1'b0;
      tick();

      // Full clear: lost port A write late in the sequence and an ignored clr_req.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_n = 0;
      while (busy_rf && busy_n < 40) begin
         busy_n++;
         idle_inputs();
         if (busy_n == 5) clr_req = 1'b1;
         if (busy_n == 13) begin
            en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'd9; din_a = 16'h7777;
         end
         tick();
      end
      idle_inputs();
      check("clr_busy_cycles", 16'(busy_n), 16'd16);
      check("clr_busy_end_wf", {15'd0, busy_wf}, 16'h0);
      tick();
      check("clr_no_restart", {15'd0, busy_rf}, 16'h0);
      read_all("clr_rd", 16, 16'h0);

      // Vector table: byte enables, read-during-write, collisions, holds.
      for (int i = 0; i < 13; i++) step($sformatf("vec%0d", i), tbl[i]);
      flush();

      // Exact read latency on port B, then hold with re_b low.
      for (int k = 1; k <= 5; k++) begin
         idle_inputs();
         if (k == 1) begin re_b = 1'b1; addr_b = 4'd3; end
         else if (k == 2) begin re_b = 1'b1; addr_b = 4'd2; end
         else addr_b = 4'd7;
         tick();
         exp_b = (k == LAT) ? 16'h12EF : 16'hA5A5;
         check($sformatf("lat_b_rf_k%0d", k), dout_b_rf, exp_b);
         check($sformatf("lat_b_wf_k%0d", k), dout_b_wf, exp_b);
      end

      // Reset mid-clear at counter 7: partial clear survives.
      for (int i = 0; i < 16; i++) begin
         idle_inputs();
         en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'(i); din_a = 16'h1000 + 16'(i);
         tick();
      end
      idle_inputs();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (7) tick();
      check("midclr_busy_before", {15'd0, busy_rf}, 16'h1);
      reset = 1'b1;
      #1;
      check("midclr_busy_rf", {15'd0, busy_rf}, 16'h0);
      check("midclr_busy_wf", {15'd0, busy_wf}, 16'h0);
      check("midclr_dout_a", dout_a_rf, 16'h0);
      check("midclr_dout_b", dout_b_wf, 16'h0);
      #2 reset = 1'b0;
      tick();
      check("midclr_stays_idle", {15'd0, busy_rf}, 16'h0);
      read_all("midclr_rd", 7, 16'h1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_dp_be_sync.md
RAM_DP_BE_SYNC -- requirements
Module: ram_dp_be_sync

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: address bits per port; depth is 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter RDW_MODE, default RDW_READ_FIRST: read-during-write policy for both ports.
REQ-004 SHALL have parameter CLR_VALUE, default all-zero: word written by the clear sequencer.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port en_a, input, 1: port A access enable.
REQ-008 SHALL have port we_a, input, 1: port A write; effective only with en_a.
REQ-009 SHALL have port be_a, input, NB: port A byte enables; bit i selects data[8i+7:8i].
REQ-010 SHALL have port addr_a, input, ADDR_WIDTH: port A address.
REQ-011 SHALL have port din_a, input, DATA_WIDTH: port A write data.
REQ-012 SHALL have port dout_a, output, DATA_WIDTH: port A registered read data.
REQ-013 SHALL have port re_b, input, 1: port B (read-only) enable.
REQ-014 SHALL have port addr_b, input, ADDR_WIDTH: port B address.
REQ-015 SHALL have port dout_b, output, DATA_WIDTH: port B registered read data.
REQ-016 SHALL have port clr_req, input, 1: single-cycle request to start a full-memory clear.
REQ-017 SHALL have port clr_busy, output, 1: high while a clear is in progress.
REQ-018 SHALL have port collision, output, 1: port B read hit the address being written; aligned with dout_b.

Function
REQ-019 Read latency SHALL be 1 cycle: data for an address sampled at edge N is on dout at edge N+1.
REQ-020 With en_a low, dout_a SHALL hold its value; with re_b low, dout_b and collision SHALL hold.
REQ-021 A write SHALL update only the byte lanes whose be_a bit is 1; be_a all-zero SHALL write nothing.
REQ-022 RDW_READ_FIRST: a read of the address being written SHALL return the old word.
REQ-023 RDW_WRITE_FIRST: the same read SHALL return the merged word (new bytes where be_a=1, old bytes elsewhere).
REQ-024 REQ-022/023 SHALL apply to port A self-reads and to port B reads of the port A write address.
REQ-025 collision SHALL be 1 for one cycle when re_b is high and addr_b equals an active write address (port A or clear) with nonzero byte enables.
REQ-026 The FSM SHALL have states IDLE and CLEAR; in IDLE, clr_req=1 SHALL enter CLEAR with the clear counter at 0.
REQ-027 CLEAR SHALL write CLR_VALUE, all lanes, to counter address, one word per cycle, incrementing from 0 to 2**ADDR_WIDTH-1.
REQ-028 After writing the last address, the FSM SHALL return to IDLE; clr_busy SHALL be high for exactly 2**ADDR_WIDTH cycles, starting the cycle after clr_req.
REQ-029 During CLEAR, port A writes SHALL be discarded, port A reads SHALL be serviced, and clr_req SHALL be ignored.
REQ-030 Port B SHALL stay fully functional during CLEAR; the clear write counts as a write for REQ-022..025.
REQ-031 Addresses SHALL wrap modulo 2**ADDR_WIDTH with no out-of-range state.

Reset
REQ-032 reset SHALL force dout_a=0, dout_b=0, collision=0, clr_busy=0, FSM=IDLE, counter=0, and any output pipeline register to 0.
REQ-033 Memory contents SHALL NOT be reset; reset during CLEAR SHALL abandon the clear and leave it partially applied.

Configuration
REQ-034 With RAM_DP_OUTREG_EN defined, an extra output register stage SHALL be added to dout_a, dout_b and collision: latency 2, with enables pipelined alongside.
REQ-035 Without RAM_DP_OUTREG_EN, latency SHALL be 1 as in REQ-019.

Structure
REQ-036 Package ram_pkg SHALL hold the rdw_mode_t enum (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1) and the clr_state_t enum (IDLE, CLEAR).
REQ-037 The clear FSM and counter SHALL be the sub-module ram_clr_fsm; the storage array SHALL remain in ram_dp_be_sync.

Verification (ADDR_WIDTH=4, DATA_WIDTH=16, no macro unless stated)
REQ-038 Write 0xBEEF to addr 3 with be_a=11, then write 0x1200 to addr 3 with be_a=10, then read addr 3 -> dout_a=0x12EF one cycle later.
REQ-039 RDW_READ_FIRST with mem[5]=0x1111: same cycle, A writes 0x2222 to addr 5 and B reads addr 5 -> dout_b=0x1111, collision=1. Repeat with RDW_WRITE_FIRST -> dout_b=0x2222, collision=1.
REQ-040 Pulse clr_req -> clr_busy high for 16 cycles; a port A write attempted during the clear is lost; every address then reads CLR_VALUE.
REQ-041 Assert reset at clear counter=7 -> clr_busy=0 immediately; addrs 0..6 hold CLR_VALUE, addrs 7..15 hold prior data.
REQ-042 With RAM_DP_OUTREG_EN: read addr 2 holding 0xA5A5 -> dout_b=0xA5A5 after exactly 2 cycles; re_b=0 afterwards -> dout_b holds.
